adffe_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one WIDTH-bit async-reset enable register (ADFFE-style bank) between NREQ requesters.
- Grants one requester at a time.
- Drives the register's enable and data for exactly one cycle per grant.
- Acknowledges the winner, then enforces a programmable hold-off before the next grant.
- Sits between requesting control blocks and the shared state register; the register bank is contained in this block and exposed on Q.

---
 rtl/adffe_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_adffe_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adffe_write_arbiter.sv
// ---------------------------------------------------------------------------
// adffe_write_arbiter
//   Round-robin arbiter sharing one WIDTH-bit async-reset enable register
//   between NREQ requesters. Each grant produces one WRITE cycle (EN=1,
//   D=captured data). The edge that ends WRITE loads Q and pulses ACK for the
//   winner. HOLD_CYCLES idle cycles follow before the next grant.
//
// Optional feature macro: ADFFE_ARB_CLR_EN
//   When defined, adds a CLR input. CLR sampled in IDLE has priority over
//   every REQ bit and writes 0 to Q. A clear write produces no ACK and leaves
//   GNT_ID and the round-robin pointer unchanged.
//
// Ports
//   CLK     in   clock, rising edge
//   ARST    in   async reset, active low
//   CLR     in   (ADFFE_ARB_CLR_EN only) clear request
//   REQ     in   [NREQ]        level request per requester
//   D_IN    in   [NREQ*WIDTH]  data per requester, slice i at [i*WIDTH +: WIDTH]
//   ACK     out  [NREQ]        one-cycle write-done pulse, one-hot
//   EN      out                register enable, high during WRITE
//   D       out  [WIDTH]       write data during WRITE, else 0
//   Q       out  [WIDTH]       shared register contents
//   GNT_ID  out  [clog2(NREQ)] current/last granted requester
//   BUSY    out                high in WRITE and HOLD
// ---------------------------------------------------------------------------
module adffe_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    ARST,
`ifdef ADFFE_ARB_CLR_EN
    input  logic                    CLR,
`endif
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   D_IN,
    output logic [NREQ-1:0]         ACK,
    output logic                    EN,
    output logic [WIDTH-1:0]        D,
    output logic [WIDTH-1:0]        Q,
    output logic [$clog2(NREQ)-1:0] GNT_ID,
    output logic                    BUSY
);

    localparam int IW = $clog2(NREQ);
    // Reload value for the hold counter. It counts down to 0 inclusive.
    localparam logic [3:0] HOLD_LAST = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   last_q;     // last granted requester (round-robin pointer)
    logic [3:0]      hold_q;     // remaining HOLD cycles minus one
    logic            clr_wr_q;   // current WRITE is a clear, suppress ACK

    logic            clr_req;
    logic            win_vld;
    logic [IW-1:0]   win_id;
    logic [IW-1:0]   cand;

    logic [NREQ-1:0][WIDTH-1:0] din_a;
    assign din_a = D_IN;

`ifdef ADFFE_ARB_CLR_EN
    assign clr_req = CLR;
`else
    assign clr_req = 1'b0;
`endif

    // First set REQ bit searching last_q+1, last_q+2, ... modulo NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!win_vld && REQ[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Single-process FSM. All outputs are registered.
    // D doubles as the captured write data. It is loaded at the grant edge,
    // so later D_IN changes cannot affect the write in flight.
    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NREQ - 1);
            hold_q   <= '0;
            clr_wr_q <= 1'b0;
            ACK      <= '0;
            EN       <= 1'b0;
            D        <= '0;
            Q        <= '0;
            GNT_ID   <= '0;
            BUSY     <= 1'b0;
        end else begin
            ACK <= '0;
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_q  <= S_WRITE;
                        clr_wr_q <= 1'b1;
                        EN       <= 1'b1;
                        D        <= '0;
                        BUSY     <= 1'b1;
                    end else if (win_vld) begin
                        state_q  <= S_WRITE;
                        clr_wr_q <= 1'b0;
                        GNT_ID   <= win_id;
                        last_q   <= win_id;
                        EN       <= 1'b1;
                        D        <= din_a[win_id];
                        BUSY     <= 1'b1;
                    end
                end
                S_WRITE: begin
                    Q  <= D;
                    EN <= 1'b0;
                    D  <= '0;
                    if (!clr_wr_q) ACK[GNT_ID] <= 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state_q <= S_HOLD;
                        hold_q  <= HOLD_LAST;
                    end else begin
                        state_q <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == 4'd0) begin
                        state_q <= S_IDLE;
                        BUSY    <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    BUSY    <= 1'b0;
                    EN      <= 1'b0;
                    D       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adffe_write_arbiter.sv
// Testbench for adffe_write_arbiter. Three instances with HOLD_CYCLES 2, 0
// and 3 share the same stimulus. A timing model keyed on the grant edge
// number predicts every output. Directed literal checks pin the model.
module tb_adffe_write_arbiter;

    localparam int NR = 4;
    localparam int NI = 3;
    localparam int HV [NI] = '{2, 0, 3};

    logic           CLK = 1'b0;
    logic           ARST = 1'b0;
    logic           CLR = 1'b0;
    logic [NR-1:0]  REQ = '0;
    logic [7:0]     D_IN = '0;

    logic [NR-1:0]  ack  [NI];
    logic           en   [NI];
    logic [1:0]     d    [NI];
    logic [1:0]     q    [NI];
    logic [1:0]     gnt  [NI];
    logic           busy [NI];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        adffe_write_arbiter #(.NREQ(NR), .WIDTH(2), .HOLD_CYCLES(HV[gi])) u_dut (
            .CLK   (CLK),
            .ARST  (ARST),
`ifdef ADFFE_ARB_CLR_EN
            .CLR   (CLR),
`endif
            .REQ   (REQ),
            .D_IN  (D_IN),
            .ACK   (ack[gi]),
            .EN    (en[gi]),
            .D     (d[gi]),
            .Q     (q[gi]),
            .GNT_ID(gnt[gi]),
            .BUSY  (busy[gi])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // k counts active edges. g is the grant edge of the latest write. A
    // write is visible on EN after edge g, loads Q at edge g+1, and the
    // next grant may happen no earlier than edge g+H+2.
    int       k = 0;
    int       g     [NI];
    int       nok   [NI];
    int       mlast [NI];
    int       mgnt  [NI];
    int       mdat  [NI];
    int       mq    [NI];
    bit       mnoack[NI];

    always @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            for (int i = 0; i < NI; i++) begin
                g[i] = k - 100; nok[i] = 0; mlast[i] = NR - 1; mgnt[i] = 0;
                mdat[i] = 0; mq[i] = 0; mnoack[i] = 0;
            end
        end else begin
            k++;
            for (int i = 0; i < NI; i++) begin
                if (k == g[i] + 1) mq[i] = mdat[i];
                if (k >= nok[i]) begin
                    if (CLR) begin
                        g[i] = k; nok[i] = k + HV[i] + 2; mdat[i] = 0; mnoack[i] = 1;
                    end else if (REQ != 0) begin
                        int w;
                        bit found;
                        w = 0; found = 0;
                        for (int s = 1; s <= NR; s++)
                            if (!found && REQ[(mlast[i] + s) % NR]) begin
                                found = 1; w = (mlast[i] + s) % NR;
                            end
                        g[i] = k; nok[i] = k + HV[i] + 2; mnoack[i] = 0;
                        mgnt[i] = w; mlast[i] = w; mdat[i] = int'(D_IN[w*2 +: 2]);
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge CLK) begin
        for (int i = 0; i < NI; i++) begin
            bit       e_en, e_busy;
            int       e_ack;
            e_en   = ARST && (k == g[i]);
            e_busy = ARST && (k >= g[i]) && (k <= g[i] + HV[i]);
            e_ack  = (ARST && k == g[i] + 1 && !mnoack[i]) ? (1 << mgnt[i]) : 0;
            chk($sformatf("u%0d.EN k=%0d", i, k),     en[i],   e_en);
            chk($sformatf("u%0d.D k=%0d", i, k),      d[i],    e_en ? mdat[i] : 0);
            chk($sformatf("u%0d.Q k=%0d", i, k),      q[i],    mq[i]);
            chk($sformatf("u%0d.ACK k=%0d", i, k),    ack[i],  e_ack);
            chk($sformatf("u%0d.BUSY k=%0d", i, k),   busy[i], e_busy);
            chk($sformatf("u%0d.GNT_ID k=%0d", i, k), gnt[i],  mgnt[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK); #2;
    endtask

    task automatic do_reset();
        ARST = 1'b0; REQ = '0; CLR = 1'b0;
        step(); step();
        ARST = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        chk("rst.Q", q[0], 0);
        chk("rst.BUSY", busy[0], 0);
        chk("rst.GNT_ID", gnt[0], 0);

        // Single write from requester 2, HOLD=2.
        REQ = 4'b0100; D_IN = 8'b00_10_00_00;
        step();
        chk("sw.EN", en[0], 1); chk("sw.D", d[0], 2'b10); chk("sw.BUSY0", busy[0], 1);
        step();
        REQ = '0;
        chk("sw.EN1", en[0], 0); chk("sw.Q", q[0], 2'b10);
        chk("sw.ACK", ack[0], 4'b0100); chk("sw.BUSY1", busy[0], 1);
        step();
        chk("sw.ACK1", ack[0], 0); chk("sw.BUSY2", busy[0], 1);
        step();
        chk("sw.BUSY3", busy[0], 0); chk("sw.Qhold", q[0], 2'b10);

        // Round robin, all requests held.
        do_reset();
        REQ = 4'b1111; D_IN = 8'b11_10_01_00;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("rr.GNT%0d", n), gnt[0], n % 4);
            chk($sformatf("rr.EN%0d", n), en[0], 1);
            step();
            chk($sformatf("rr.Q%0d", n), q[0], n % 4);
            chk($sformatf("rr.ACK%0d", n), ack[0], 1 << (n % 4));
            step(); step();
        end

        // Hold-off: HOLD=0 toggles EN, HOLD=3 writes every 5th cycle.
        do_reset();
        REQ = 4'b0001; D_IN = 8'h01;
        for (int j = 0; j < 10; j++) begin
            step();
            chk($sformatf("ho0.EN%0d", j), en[1], (j % 2) == 0);
            chk($sformatf("ho3.EN%0d", j), en[2], (j % 5) == 0);
        end

        // Data capture at the grant edge.
        do_reset();
        REQ = 4'b0010; D_IN = 8'b00_00_01_00;
        step();
        D_IN = 8'b00_00_11_00;
        step();
        chk("dc.Q", q[0], 2'b01);
        REQ = '0;
        step(); step(); step();

        // Reset in the middle of a WRITE.
        do_reset();
        REQ = 4'b0001; D_IN = 8'h03;
        step();
        chk("rw.EN", en[0], 1);
        ARST = 1'b0; #1;
        chk("rw.Q", q[0], 0); chk("rw.EN0", en[0], 0);
        chk("rw.ACK", ack[0], 0); chk("rw.BUSY", busy[0], 0);
        step();
        ARST = 1'b1; REQ = 4'b1111; D_IN = 8'b11_10_01_00;
        step();
        chk("rw.GNT", gnt[0], 0);
        step();
        chk("rw.ACK0", ack[0], 4'b0001);

`ifdef ADFFE_ARB_CLR_EN
        // CLR beats REQ in IDLE, gives no ACK, and keeps the pointer.
        do_reset();
        REQ = 4'b0001; D_IN = 8'h03;
        step();
        step(); chk("cl.Q3", q[0], 2'b11);
        step();
        step(); CLR = 1'b1;
        step(); CLR = 1'b0;
        chk("cl.EN", en[0], 1); chk("cl.D", d[0], 0);
        step();
        chk("cl.Q0", q[0], 0); chk("cl.ACK", ack[0], 0);
        step(); step(); step();
        chk("cl.GNT", gnt[0], 0); chk("cl.EN2", en[0], 1);
        step();
        chk("cl.ACK2", ack[0], 4'b0001); chk("cl.Q", q[0], 2'b11);
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            REQ  = 4'($urandom);
            D_IN = 8'($urandom);
`ifdef ADFFE_ARB_CLR_EN
            CLR  = ($urandom_range(0, 7) == 0);
`endif
            ARST = ($urandom_range(0, 60) != 0);
            step();
            ARST = 1'b1;
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
